// File: rtl/pipe_stage_latch.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_latch
//  Description : Generic pipeline-stage register carrying an opaque data
//                bundle and a control bundle over a valid/ready handshake.
//                Supports debug single-step gating, synchronous flush,
//                bubble-safe control zeroing and a saturating bubble counter.
//                Define PIPE_LATCH_SKID_EN to add a two-entry skid buffer
//                with a registered o_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_latch #(
  parameter int DATA_WIDTH = 128,
  parameter int CTRL_WIDTH = 24,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_step,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [CTRL_WIDTH-1:0] i_ctrl,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CTRL_WIDTH-1:0] o_ctrl,
  output logic [1:0]            o_count,
  output logic [CNT_WIDTH-1:0]  o_bubbles
);

  localparam logic [CNT_WIDTH-1:0] c_bub_max = '1;
  localparam logic [CNT_WIDTH-1:0] c_bub_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Head entry: the one presented downstream.
  logic                  r_head_valid_q, w_head_valid_d;
  logic [DATA_WIDTH-1:0] r_head_data_q,  w_head_data_d;
  logic [CTRL_WIDTH-1:0] r_head_ctrl_q,  w_head_ctrl_d;
  logic [CNT_WIDTH-1:0]  r_bubbles_q,    w_bubbles_d;

  logic w_in_xfer;
  logic w_out_xfer;

`ifdef PIPE_LATCH_SKID_EN
  // Skid entry: catches the one input accepted while the head is stalled.
  logic                  r_skid_valid_q, w_skid_valid_d;
  logic [DATA_WIDTH-1:0] r_skid_data_q,  w_skid_data_d;
  logic [CTRL_WIDTH-1:0] r_skid_ctrl_q,  w_skid_ctrl_d;

  // Ready depends only on registered state, breaking the i_ready path.
  assign o_ready = ~i_reset & i_step & ~r_skid_valid_q;
  assign o_count = {1'b0, r_head_valid_q} + {1'b0, r_skid_valid_q};
`else
  // Ready passes through i_ready so a full head can refill in the same cycle.
  assign o_ready = ~i_reset & i_step & (~r_head_valid_q | i_ready);
  assign o_count = {1'b0, r_head_valid_q};
`endif

  assign w_in_xfer  = i_valid & o_ready;
  assign w_out_xfer = r_head_valid_q & i_ready & i_step;

  assign o_valid   = r_head_valid_q;
  assign o_data    = r_head_data_q;
  assign o_ctrl    = r_head_valid_q ? r_head_ctrl_q : '0;
  assign o_bubbles = r_bubbles_q;

  // Next-state for head/skid entries and the bubble counter; flush wins over transfers.
  always_comb begin
    w_head_valid_d = r_head_valid_q;
    w_head_data_d  = r_head_data_q;
    w_head_ctrl_d  = r_head_ctrl_q;
    w_bubbles_d    = r_bubbles_q;
`ifdef PIPE_LATCH_SKID_EN
    w_skid_valid_d = r_skid_valid_q;
    w_skid_data_d  = r_skid_data_q;
    w_skid_ctrl_d  = r_skid_ctrl_q;
`endif
    if (i_flush) begin
      w_head_valid_d = 1'b0;
      w_head_data_d  = '0;
      w_head_ctrl_d  = '0;
`ifdef PIPE_LATCH_SKID_EN
      w_skid_valid_d = 1'b0;
`endif
    end else begin
      // Bubbles are counted only on stepped edges with nothing presented.
      if (i_step && !r_head_valid_q && (r_bubbles_q != c_bub_max)) begin
        w_bubbles_d = r_bubbles_q + c_bub_one;
      end
`ifdef PIPE_LATCH_SKID_EN
      if (!r_head_valid_q || w_out_xfer) begin
        // Skid is only ever full while o_ready=0, so no input competes here.
        if (r_skid_valid_q) begin
          w_head_valid_d = 1'b1;
          w_head_data_d  = r_skid_data_q;
          w_head_ctrl_d  = r_skid_ctrl_q;
          w_skid_valid_d = 1'b0;
        end else if (w_in_xfer) begin
          w_head_valid_d = 1'b1;
          w_head_data_d  = i_data;
          w_head_ctrl_d  = i_ctrl;
        end else begin
          w_head_valid_d = 1'b0;
        end
      end else if (w_in_xfer) begin
        w_skid_valid_d = 1'b1;
        w_skid_data_d  = i_data;
        w_skid_ctrl_d  = i_ctrl;
      end
`else
      if (w_in_xfer) begin
        w_head_valid_d = 1'b1;
        w_head_data_d  = i_data;
        w_head_ctrl_d  = i_ctrl;
      end else if (w_out_xfer) begin
        w_head_valid_d = 1'b0;
      end
`endif
    end
  end

  // State registers with synchronous reset to the empty stage.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_head_valid_q <= 1'b0;
      r_head_data_q  <= '0;
      r_head_ctrl_q  <= '0;
      r_bubbles_q    <= '0;
`ifdef PIPE_LATCH_SKID_EN
      r_skid_valid_q <= 1'b0;
      r_skid_data_q  <= '0;
      r_skid_ctrl_q  <= '0;
`endif
    end else begin
      r_head_valid_q <= w_head_valid_d;
      r_head_data_q  <= w_head_data_d;
      r_head_ctrl_q  <= w_head_ctrl_d;
      r_bubbles_q    <= w_bubbles_d;
`ifdef PIPE_LATCH_SKID_EN
      r_skid_valid_q <= w_skid_valid_d;
      r_skid_data_q  <= w_skid_data_d;
      r_skid_ctrl_q  <= w_skid_ctrl_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_latch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_latch
//  Description : Self-checking bench for pipe_stage_latch with a scoreboard
//                queue of accepted entries and a monitor that checks every
//                output transfer in order, plus directed status checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_latch;

  localparam int DW = 128;
  localparam int CW = 24;
  localparam int NW = 4;

  logic          i_clk = 1'b0;
  logic          i_reset, i_step, i_flush, i_valid, i_ready;
  logic          o_ready, o_valid;
  logic [DW-1:0] i_data, o_data;
  logic [CW-1:0] i_ctrl, o_ctrl;
  logic [1:0]    o_count;
  logic [NW-1:0] o_bubbles;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW+CW-1:0] sb[$];

  localparam logic [DW-1:0] c_d1 = 128'h0123_4567_89AB_CDEF_0000_0000_0000_1234;
  localparam logic [DW-1:0] c_e1 = 128'hE1E1_0000_0000_0000_0000_0000_0000_00E1;
  localparam logic [DW-1:0] c_e2 = 128'hE2E2_0000_0000_0000_0000_0000_0000_00E2;
  localparam logic [DW-1:0] c_f1 = 128'hF1;
  localparam logic [DW-1:0] c_f2 = 128'hF2;
  localparam logic [DW-1:0] c_f3 = 128'hF3;
  localparam logic [DW-1:0] c_g1 = 128'h6161_6161;
  localparam logic [DW-1:0] c_h1 = 128'hA1;
  localparam logic [DW-1:0] c_h2 = 128'hA2;

`ifdef PIPE_LATCH_SKID_EN
  localparam logic [1:0] c_full_cnt   = 2'd2;
  localparam logic       c_ready_busy = 1'b1;
  localparam logic [1:0] c_cnt_after1 = 2'd1;
`else
  localparam logic [1:0] c_full_cnt   = 2'd1;
  localparam logic       c_ready_busy = 1'b0;
  localparam logic [1:0] c_cnt_after1 = 2'd0;
`endif

  pipe_stage_latch #(
    .DATA_WIDTH(DW),
    .CTRL_WIDTH(CW),
    .CNT_WIDTH (NW)
  ) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_step   (i_step),
    .i_flush  (i_flush),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_data   (i_data),
    .i_ctrl   (i_ctrl),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_data   (o_data),
    .o_ctrl   (o_ctrl),
    .o_count  (o_count),
    .o_bubbles(o_bubbles)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  // Monitor: records accepted inputs and checks output transfers in FIFO order.
  initial begin
    logic [DW+CW-1:0] exp_e;
    forever begin
      @(negedge i_clk);
      if (!i_reset && !i_flush && i_step && o_valid && i_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: got %0h/%0h expected no output", o_data, o_ctrl);
        end else begin
          exp_e = sb.pop_front();
          if ({o_data, o_ctrl} !== exp_e) begin
            n_err++;
            $display("FAIL sb_out: got %0h/%0h expected %0h/%0h",
                     o_data, o_ctrl, exp_e[DW+CW-1:CW], exp_e[CW-1:0]);
          end
        end
      end
      if (!i_reset && !i_flush && i_valid && o_ready) sb.push_back({i_data, i_ctrl});
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_step = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
    i_ready = 1'b0; i_data = '0; i_ctrl = '0;
    tick; tick;
    chk("rst_valid", DW'(o_valid), 0);
    chk("rst_ctrl", DW'(o_ctrl), 0);
    chk("rst_data", o_data, 0);
    chk("rst_count", DW'(o_count), 0);
    chk("rst_bubbles", DW'(o_bubbles), 0);
    chk("rst_ready", DW'(o_ready), 0);

    // First entry: one-cycle latency, reset-exit edge counts a bubble.
    i_reset = 1'b0; i_step = 1'b1; i_valid = 1'b1; i_data = c_d1; i_ctrl = 24'h0000A5;
    tick;
    i_valid = 1'b0;
    chk("t1_valid", DW'(o_valid), 1);
    chk("t1_data", o_data, c_d1);
    chk("t1_ctrl", DW'(o_ctrl), 24'h0000A5);
    chk("t1_bubbles", DW'(o_bubbles), 1);
    i_ready = 1'b1;
    tick;
    chk("t1_drain_valid", DW'(o_valid), 0);
    chk("t1_drain_ctrl0", DW'(o_ctrl), 0);
    chk("t1_data_hold", o_data, c_d1);
    chk("t1_drain_bub", DW'(o_bubbles), 1);

    // Stream of 8 at full rate.
    for (int k = 0; k < 8; k++) begin
      i_valid = 1'b1;
      i_data  = {96'h5000_0000_0000_0000_0000_0000, 32'(k)};
      i_ctrl  = 24'h000100 + 24'(k);
      tick;
      chk("stream_valid", DW'(o_valid), 1);
      chk("stream_count", DW'(o_count), 1);
      chk("stream_data", o_data, {96'h5000_0000_0000_0000_0000_0000, 32'(k)});
    end
    i_valid = 1'b0;
    tick;
    chk("stream_end_valid", DW'(o_valid), 0);

    // Back-pressure: second push goes to skid (skid build) or is refused.
    i_ready = 1'b0; i_valid = 1'b1; i_data = c_e1; i_ctrl = 24'h0000E1;
    tick;
    i_data = c_e2; i_ctrl = 24'h0000E2;
    chk("bp_ready_held", DW'(o_ready), DW'(c_ready_busy));
    tick;
    i_valid = 1'b0;
    chk("bp_count_full", DW'(o_count), DW'(c_full_cnt));
    chk("bp_ready_full", DW'(o_ready), 0);
    chk("bp_head_data", o_data, c_e1);
    i_ready = 1'b1;
    tick;
    chk("bp_count_drain1", DW'(o_count), DW'(c_cnt_after1));
    chk("bp_ready_back", DW'(o_ready), 1);
    tick;
    chk("bp_count_empty", DW'(o_count), 0);

    // Flush with the stage full and an input offered.
    i_reset = 1'b1; i_ready = 1'b0;
    tick;
    i_reset = 1'b0;
    sb.delete();
    i_valid = 1'b1; i_data = c_f1; i_ctrl = 24'h0000F1;
    tick;
    i_data = c_f2; i_ctrl = 24'h0000F2;
    tick;
    chk("fl_pre_count", DW'(o_count), DW'(c_full_cnt));
    i_flush = 1'b1; i_data = c_f3; i_ctrl = 24'h0000F3;
    tick;
    i_flush = 1'b0; i_valid = 1'b0;
    sb.delete();
    chk("fl_valid", DW'(o_valid), 0);
    chk("fl_ctrl", DW'(o_ctrl), 0);
    chk("fl_data", o_data, 0);
    chk("fl_count", DW'(o_count), 0);
    chk("fl_bubbles", DW'(o_bubbles), 1);
    tick;
    chk("fl_dropped", DW'(o_valid), 0);
    chk("fl_bub_next", DW'(o_bubbles), 2);

    // Debug step gating: frozen for 5 cycles, then the transfer completes.
    i_valid = 1'b1; i_data = c_g1; i_ctrl = 24'h000061;
    tick;
    i_valid = 1'b0; i_ready = 1'b1; i_step = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("step_valid", DW'(o_valid), 1);
      chk("step_data", o_data, c_g1);
      chk("step_ready", DW'(o_ready), 0);
      chk("step_bub", DW'(o_bubbles), 3);
    end
    i_step = 1'b1;
    tick;
    chk("step_done_valid", DW'(o_valid), 0);
    chk("step_done_bub", DW'(o_bubbles), 3);
    chk("sb_drained", DW'(sb.size()), 0);

    // Saturation of the 4-bit bubble counter.
    for (int k = 0; k < 20; k++) tick;
    chk("bub_saturate", DW'(o_bubbles), 15);

    // Reset asserted mid-stall.
    i_ready = 1'b0; i_valid = 1'b1; i_data = c_h1; i_ctrl = 24'h0000A1;
    tick;
    i_data = c_h2; i_ctrl = 24'h0000A2;
    tick;
    i_valid = 1'b0; i_reset = 1'b1;
    tick;
    i_reset = 1'b0;
    sb.delete();
    chk("mrst_valid", DW'(o_valid), 0);
    chk("mrst_count", DW'(o_count), 0);
    chk("mrst_bub", DW'(o_bubbles), 0);
    chk("mrst_data", o_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
